// File: rtl/uart_rx_fifo.sv
//------------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive-side buffer placed directly after a UART receiver. A small capture
//   FSM watches the receiver handshake, builds one entry per frame (8 data
//   bits plus parity/framing error tags) and pushes it into a synchronous
//   FIFO. The host drains the FIFO through a first-word-fall-through port.
//   Frames arriving while the FIFO is full are dropped and reported through
//   a sticky overrun flag.
//
// Parameters:
//   p_depth    number of FIFO entries (power of two, minimum 2)
//   p_cnt_len  occupancy counter width, derived from p_depth
//   p_af_thr   almost-full threshold (only with UART_RX_FIFO_ALMOST_FULL_EN)
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous reset, active high
//   rx_data_i        receiver data byte
//   rx_ready_i       receiver data-ready level, rising edge marks a new byte
//   rx_busy_i        receiver busy, low means the frame has ended
//   rx_parity_err_i  receiver parity error
//   rx_framing_err_i receiver framing error
//   rd_en_i          host pop request
//   rd_data_o        head entry data byte
//   rd_err_o         head entry tags, [1] framing, [0] parity
//   rd_valid_o       head entry present
//   empty_o          FIFO empty
//   full_o           FIFO full
//   count_o          occupancy, 0..p_depth
//   overrun_o        sticky, a frame was dropped because the FIFO was full
//   almost_full_o    count_o >= p_af_thr (only with UART_RX_FIFO_ALMOST_FULL_EN)
//   clr_overrun_i    clears overrun_o
//
// Build option:
//   Define UART_RX_FIFO_ALMOST_FULL_EN to add p_af_thr and almost_full_o.
//------------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int p_depth   = 16,
   parameter int p_cnt_len = $clog2(p_depth) + 1
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,
   parameter int p_af_thr  = p_depth - 2
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [7:0]           rx_data_i,
   input  logic                 rx_ready_i,
   input  logic                 rx_busy_i,
   input  logic                 rx_parity_err_i,
   input  logic                 rx_framing_err_i,
   input  logic                 rd_en_i,
   output logic [7:0]           rd_data_o,
   output logic [1:0]           rd_err_o,
   output logic                 rd_valid_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic [p_cnt_len-1:0] count_o,
   output logic                 overrun_o,
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   output logic                 almost_full_o,
`endif
   input  logic                 clr_overrun_i
);

   localparam int c_ptrLen = $clog2(p_depth);
   localparam logic [p_cnt_len-1:0] c_fullCount = p_cnt_len'(p_depth);

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_COLLECT = 2'd1,
      CAP_COMMIT  = 2'd2
   } capState_t;

   capState_t               r_capState;
   capState_t               w_capNext;
   logic                    r_rxReadyQ;
   logic [7:0]              r_capData;
   logic                    r_capPar;
   logic                    r_capFrm;
   logic [9:0]              r_mem [p_depth];
   logic [c_ptrLen-1:0]     r_wrPtr;
   logic [c_ptrLen-1:0]     r_rdPtr;
   logic [p_cnt_len-1:0]    r_count;
   logic                    r_overrun;
   logic                    w_rise;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push;
   logic                    w_drop;
   logic [9:0]              w_head;

   assign w_rise  = rx_ready_i & ~r_rxReadyQ;
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_fullCount);
   assign w_pop   = rd_en_i & ~w_empty;

   // Remember last cycle's data-ready so a new byte is seen only on its
   // rising edge. Cleared by reset, so a level already high out of reset
   // counts as a new byte on the first cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rxReadyQ <= 1'b0;
      end else begin
         r_rxReadyQ <= rx_ready_i;
      end
   end

   // Capture FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_capState <= CAP_IDLE;
      end else begin
         r_capState <= w_capNext;
      end
   end

   // Next state and commit decision. A frame is accepted in the commit cycle
   // when there is room, or when the FIFO is full but the host pops in the
   // same cycle and so frees the slot being written. Rises seen outside of
   // idle are ignored because the receiver never produces them.
   always_comb begin
      w_capNext = r_capState;
      w_push    = 1'b0;
      w_drop    = 1'b0;
      case (r_capState)
         CAP_IDLE: begin
            if (w_rise) begin
               w_capNext = CAP_COLLECT;
            end
         end
         CAP_COLLECT: begin
            if (!rx_busy_i) begin
               w_capNext = CAP_COMMIT;
            end
         end
         CAP_COMMIT: begin
            w_capNext = CAP_IDLE;
            if (!w_full || rd_en_i) begin
               w_push = 1'b1;
            end else begin
               w_drop = 1'b1;
            end
         end
         default: begin
            w_capNext = CAP_IDLE;
         end
      endcase
   end

   // Frame assembly. The byte is latched on the rise; error tags are then
   // OR-accumulated for the whole collect phase, including the cycle in
   // which busy is seen low, so a late framing error still lands in the tag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_capData <= '0;
         r_capPar  <= 1'b0;
         r_capFrm  <= 1'b0;
      end else begin
         if (r_capState == CAP_IDLE && w_rise) begin
            r_capData <= rx_data_i;
            r_capPar  <= 1'b0;
            r_capFrm  <= 1'b0;
         end else if (r_capState == CAP_COLLECT) begin
            r_capPar  <= r_capPar | rx_parity_err_i;
            r_capFrm  <= r_capFrm | rx_framing_err_i;
         end
      end
   end

   // Storage array. Only accepted frames are written, so a dropped frame
   // can never overwrite an entry the host has not read yet. No reset is
   // needed because the occupancy count guards every read.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {r_capFrm, r_capPar, r_capData};
      end
   end

   // Pointers and occupancy. Pointers are exactly log2(depth) wide so they
   // wrap on their own. A simultaneous push and pop leaves the count as is.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overrun. A drop in the same cycle as a host clear keeps the
   // flag set so the newer loss is never hidden.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (clr_overrun_i) begin
         r_overrun <= 1'b0;
      end
   end

   // First-word-fall-through read: the head entry is always presented.
   assign w_head     = r_mem[r_rdPtr];
   assign rd_data_o  = w_head[7:0];
   assign rd_err_o   = w_head[9:8];
   assign rd_valid_o = ~w_empty;
   assign empty_o    = w_empty;
   assign full_o     = w_full;
   assign count_o    = r_count;
   assign overrun_o  = r_overrun;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   assign almost_full_o = (r_count >= p_cnt_len'(p_af_thr));
`endif

endmodule
